// File: rtl/esfa_bench_ctrl_if.sv
// Host/ESFA-facing signal bundle for the benchmark sequencer.
// slave = sequencer view, master = host/testbench view.
interface esfa_bench_ctrl_if #(
  parameter int RUNS_W = 8,
  parameter int CYC_W  = 24
);
  logic              start;
  logic [RUNS_W-1:0] num_runs;
  logic              abort;
  logic              dut_do_run;
  logic              dut_is_running;
  logic              dut_was_successful;
  logic              busy;
  logic              done;
  logic              aborted;
  logic [RUNS_W-1:0] pass_count;
  logic [RUNS_W-1:0] fail_count;
  logic [RUNS_W-1:0] timeout_count;
  logic [CYC_W-1:0]  last_cycles;
  logic [CYC_W-1:0]  max_cycles;

  modport slave (
    input  start, num_runs, abort, dut_is_running, dut_was_successful,
    output dut_do_run, busy, done, aborted, pass_count, fail_count,
           timeout_count, last_cycles, max_cycles
  );

  modport master (
    output start, num_runs, abort, dut_is_running, dut_was_successful,
    input  dut_do_run, busy, done, aborted, pass_count, fail_count,
           timeout_count, last_cycles, max_cycles
  );
endinterface

// File: rtl/esfa_bench_ctrl.sv
// On-chip benchmark sequencer for ESFA: launches N runs, times each one,
// enforces start/run timeouts and accumulates pass/fail/timeout statistics.
module esfa_bench_ctrl #(
  parameter int RUNS_W     = 8,
  parameter int CYC_W      = 24,
  parameter int START_WAIT = 16,
  parameter int TIMEOUT    = 20000,
  parameter int GAP        = 4
) (
  input  logic              clk,
  input  logic              reset,
  esfa_bench_ctrl_if.slave  ctl
);

  localparam int WAIT_W = $clog2(START_WAIT + 1);
  localparam int GAP_W  = $clog2(GAP + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(START_WAIT - 1);
  // One extra GAP cycle so the start-timeout path (no SAMPLE cycle) still
  // leaves at least GAP+1 low cycles between do_run pulses.
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP);
  localparam logic [CYC_W-1:0]  CYC_LIMIT = CYC_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_RUN, S_SAMPLE, S_GAP, S_DONE
  } state_t;

  state_t            r_state,     w_state;
  logic [RUNS_W-1:0] r_runs_left, w_runs_left;
  logic [WAIT_W-1:0] r_wait,      w_wait;
  logic [GAP_W-1:0]  r_gap,       w_gap;
  logic [CYC_W-1:0]  r_cyc,       w_cyc;
  logic [RUNS_W-1:0] r_pass,      w_pass;
  logic [RUNS_W-1:0] r_fail,      w_fail;
  logic [RUNS_W-1:0] r_tmo,       w_tmo;
  logic [CYC_W-1:0]  r_last,      w_last;
  logic [CYC_W-1:0]  r_max,       w_max;
  logic              r_aborted,   w_aborted;
  logic              r_do_run;
  logic              r_busy;
  logic              r_done;
  logic              w_active;

  function automatic logic [RUNS_W-1:0] sat_inc(input logic [RUNS_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign w_active = (r_state == S_LAUNCH) || (r_state == S_RUN) ||
                    (r_state == S_SAMPLE) || (r_state == S_GAP);

  always_comb begin
    w_state     = r_state;
    w_runs_left = r_runs_left;
    w_wait      = r_wait;
    w_gap       = r_gap;
    w_cyc       = r_cyc;
    w_pass      = r_pass;
    w_fail      = r_fail;
    w_tmo       = r_tmo;
    w_last      = r_last;
    w_max       = r_max;
    w_aborted   = r_aborted;

    // Abort overrides everything else, including a same-edge timeout.
    if (ctl.abort && w_active) begin
      w_state   = S_DONE;
      w_aborted = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ctl.start) begin
            w_runs_left = ctl.num_runs;
            w_wait      = '0;
            w_pass      = '0;
            w_fail      = '0;
            w_tmo       = '0;
            w_last      = '0;
            w_max       = '0;
            w_aborted   = 1'b0;
            w_state     = (ctl.num_runs == '0) ? S_DONE : S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          if (ctl.dut_is_running) begin
            w_cyc   = CYC_W'(1);
            w_state = S_RUN;
          end else if (r_wait == WAIT_LAST) begin
            w_tmo   = sat_inc(r_tmo);
            w_gap   = '0;
            w_state = S_GAP;
          end else begin
            w_wait = r_wait + 1'b1;
          end
        end
        S_RUN: begin
          if (!ctl.dut_is_running) begin
            w_state = S_SAMPLE;
          end else if (r_cyc >= CYC_LIMIT) begin
            w_tmo   = sat_inc(r_tmo);
            w_last  = CYC_LIMIT;
            w_gap   = '0;
            w_state = S_GAP;
          end else begin
            w_cyc = r_cyc + 1'b1;
          end
        end
        S_SAMPLE: begin
          if (ctl.dut_was_successful) w_pass = sat_inc(r_pass);
          else                        w_fail = sat_inc(r_fail);
          w_last  = r_cyc;
          if (r_cyc > r_max) w_max = r_cyc;
          w_gap   = '0;
          w_state = S_GAP;
        end
        S_GAP: begin
          if ((r_gap >= GAP_LAST) && !ctl.dut_is_running) begin
            if (r_runs_left <= RUNS_W'(1)) begin
              w_runs_left = '0;
              w_state     = S_DONE;
            end else begin
              w_runs_left = r_runs_left - 1'b1;
              w_wait      = '0;
              w_state     = S_LAUNCH;
            end
          end else if (r_gap < GAP_LAST) begin
            w_gap = r_gap + 1'b1;
          end
        end
        S_DONE:  w_state = S_IDLE;
        default: w_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_runs_left <= '0;
      r_wait      <= '0;
      r_gap       <= '0;
      r_cyc       <= '0;
      r_pass      <= '0;
      r_fail      <= '0;
      r_tmo       <= '0;
      r_last      <= '0;
      r_max       <= '0;
      r_aborted   <= 1'b0;
      r_do_run    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_runs_left <= w_runs_left;
      r_wait      <= w_wait;
      r_gap       <= w_gap;
      r_cyc       <= w_cyc;
      r_pass      <= w_pass;
      r_fail      <= w_fail;
      r_tmo       <= w_tmo;
      r_last      <= w_last;
      r_max       <= w_max;
      r_aborted   <= w_aborted;
      r_do_run    <= (w_state == S_LAUNCH) || (w_state == S_RUN);
      r_busy      <= (w_state != S_IDLE);
      r_done      <= (w_state == S_DONE);
    end
  end

  assign ctl.dut_do_run    = r_do_run;
  assign ctl.busy          = r_busy;
  assign ctl.done          = r_done;
  assign ctl.aborted       = r_aborted;
  assign ctl.pass_count    = r_pass;
  assign ctl.fail_count    = r_fail;
  assign ctl.timeout_count = r_tmo;
  assign ctl.last_cycles   = r_last;
  assign ctl.max_cycles    = r_max;

endmodule

// File: tb/tb_esfa_bench_ctrl.sv
// Bench for esfa_bench_ctrl: behavioural ESFA responder plus a batch-level
// statistics model, checked every cycle from a single checking process.
module tb_esfa_bench_ctrl;
  localparam int RUNS_W = 8, CYC_W = 24, START_WAIT = 16, TIMEOUT = 200, GAP = 4;

  logic clk = 1'b0;
  logic reset;
  esfa_bench_ctrl_if #(.RUNS_W(RUNS_W), .CYC_W(CYC_W)) bus();

  esfa_bench_ctrl #(.RUNS_W(RUNS_W), .CYC_W(CYC_W), .START_WAIT(START_WAIT),
                    .TIMEOUT(TIMEOUT), .GAP(GAP)) u_dut (
    .clk(clk), .reset(reset), .ctl(bus)
  );

  always #5 clk = ~clk;

  // Per-run ESFA behaviour: start delay (-1 = never starts), length, success
  int rd[16];
  int rl[16];
  bit rs[16];

  // ESFA responder: reacts to do_run just after each rising edge
  int m_idx, m_phase, m_cnt, m_delay;
  bit m_succ, m_prev_busy;
  initial begin
    bus.dut_is_running = 1'b0;
    bus.dut_was_successful = 1'b0;
    m_idx = 0; m_phase = 0; m_cnt = 0; m_delay = 0; m_succ = 0; m_prev_busy = 0;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (reset) begin
        m_phase = 0;
        m_prev_busy = 0;
        bus.dut_is_running = 1'b0;
      end else begin
        if (bus.busy && !m_prev_busy) m_idx = 0;
        m_prev_busy = bus.busy;
        case (m_phase)
          0: if (bus.dut_do_run && m_idx < 16) begin
               m_succ = rs[m_idx];
               m_cnt  = rl[m_idx];
               if (rd[m_idx] < 0) m_phase = 3;
               else if (rd[m_idx] == 0) begin bus.dut_is_running = 1'b1; m_phase = 2; end
               else begin m_delay = rd[m_idx]; m_phase = 1; end
               m_idx++;
             end
          1: begin
               m_delay--;
               if (m_delay == 0) begin bus.dut_is_running = 1'b1; m_phase = 2; end
             end
          2: begin
               m_cnt--;
               if (m_cnt == 0) begin
                 bus.dut_is_running = 1'b0;
                 bus.dut_was_successful = m_succ;
                 m_phase = 0;
               end
             end
          3: if (!bus.dut_do_run) m_phase = 0;
          default: m_phase = 0;
        endcase
      end
    end
  end

  int n_chk, n_fail, cyc;
  int e_pass, e_fail, e_tmo, e_last, e_max;
  bit e_abt;
  bit p_do, p_busy, p_done, p_ir, done_seen;
  int hi_len, lo_len, last_hi, pulses, dones, done_cyc, fall_cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Expected batch statistics from the run table: first n_cnt runs count
  task automatic model_expect(input int n_cnt, input bit abt);
    e_pass = 0; e_fail = 0; e_tmo = 0; e_last = 0; e_max = 0; e_abt = abt;
    for (int i = 0; i < n_cnt; i++) begin
      if (rd[i] < 0 || rd[i] >= START_WAIT) e_tmo++;
      else if (rl[i] > TIMEOUT) begin e_tmo++; e_last = TIMEOUT; end
      else begin
        if (rs[i]) e_pass++; else e_fail++;
        e_last = rl[i];
        if (rl[i] > e_max) e_max = rl[i];
      end
    end
  endtask

  task automatic set_run(input int i, input int d, input int l, input bit s);
    rd[i] = d; rl[i] = l; rs[i] = s;
  endtask

  task automatic clear_runs();
    for (int i = 0; i < 16; i++) set_run(i, -1, 0, 1'b0);
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_pass"}, bus.pass_count, e_pass);
    chk({tag, "_fail"}, bus.fail_count, e_fail);
    chk({tag, "_tmo"},  bus.timeout_count, e_tmo);
    chk({tag, "_last"}, bus.last_cycles, e_last);
    chk({tag, "_max"},  bus.max_cycles, e_max);
    chk({tag, "_abt"},  bus.aborted, e_abt);
  endtask

  // One cycle: advance to the falling edge and check everything observable
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (!bus.busy) chk("idle_do_run", bus.dut_do_run, 0);
    if (bus.busy && !p_busy) begin pulses = 0; done_seen = 0; end
    if (bus.dut_do_run && !p_do) begin
      pulses++;
      if (pulses > 1) chk("do_run_low_gap_ok", lo_len >= GAP + 1, 1);
      hi_len = 0; lo_len = 0;
    end
    if (bus.dut_do_run) hi_len++; else lo_len++;
    if (!bus.dut_do_run && p_do) last_hi = hi_len;
    if (p_ir && !bus.dut_is_running) fall_cyc = cyc;
    if (p_done) chk("busy_after_done", bus.busy, 0);
    if (bus.done) begin dones++; done_cyc = cyc; done_seen = 1; end
    if (bus.done || (done_seen && !bus.busy)) chk_stats("stats");
    p_do = bus.dut_do_run; p_busy = bus.busy; p_done = bus.done; p_ir = bus.dut_is_running;
  endtask

  task automatic start_batch(input int n);
    bus.num_runs = RUNS_W'(n);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!bus.done && k < budget) begin tick(); k++; end
    chk("done_within_budget", bus.done, 1);
  endtask

  task automatic wait_model_idle();
    int k = 0;
    while (bus.dut_is_running && k < 1000) begin tick(); k++; end
    chk("esfa_idle", bus.dut_is_running, 0);
  endtask

  task automatic batch_three_pass();
    int d0;
    clear_runs();
    for (int i = 0; i < 3; i++) set_run(i, 2, 100, 1'b1);
    model_expect(3, 0);
    d0 = dones;
    start_batch(3);
    chk("t1_busy_after_start", bus.busy, 1);
    chk("t1_do_run_after_start", bus.dut_do_run, 1);
    wait_done(2000);
    chk("t1_pulses", pulses, 3);
    chk("t1_pass_lit", bus.pass_count, 3);
    chk("t1_max_lit", bus.max_cycles, 100);
    chk("t1_last_lit", bus.last_cycles, 100);
    tick();
    chk("t1_one_done", dones - d0, 1);
  endtask

  initial begin
    int k;
    n_chk = 0; n_fail = 0; cyc = 0;
    p_do = 0; p_busy = 0; p_done = 0; p_ir = 0; done_seen = 0;
    hi_len = 0; lo_len = 0; last_hi = 0; pulses = 0; dones = 0; done_cyc = 0; fall_cyc = 0;
    e_pass = 0; e_fail = 0; e_tmo = 0; e_last = 0; e_max = 0; e_abt = 0;
    clear_runs();
    reset = 1'b1; bus.start = 1'b0; bus.abort = 1'b0; bus.num_runs = '0;
    repeat (3) tick();
    chk("rst_do_run", bus.dut_do_run, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk_stats("rst");
    reset = 1'b0;
    repeat (2) tick();

    // Three identical passing runs
    batch_three_pass();

    // Two runs of different length, second fails
    clear_runs();
    set_run(0, 1, 50, 1'b1);
    set_run(1, 3, 80, 1'b0);
    model_expect(2, 0);
    start_batch(2);
    wait_done(2000);
    chk("t2_fail_lit", bus.fail_count, 1);
    chk("t2_last_lit", bus.last_cycles, 80);
    tick();

    // ESFA never starts: start timeout
    clear_runs();
    model_expect(1, 0);
    start_batch(1);
    wait_done(500);
    chk("t3_do_run_high_len", last_hi, START_WAIT);
    chk("t3_tmo_lit", bus.timeout_count, 1);
    tick();

    // ESFA runs far past TIMEOUT: run timeout, GAP holds until it drops
    clear_runs();
    set_run(0, 2, 300, 1'b1);
    model_expect(1, 0);
    start_batch(1);
    wait_done(3000);
    chk("t4_last_lit", bus.last_cycles, TIMEOUT);
    chk("t4_max_lit", bus.max_cycles, 0);
    chk("t4_done_after_fall", done_cyc > fall_cyc, 1);
    tick();
    wait_model_idle();

    // Abort during run 2 of 4
    clear_runs();
    for (int i = 0; i < 4; i++) set_run(i, 2, 100, 1'b1);
    model_expect(1, 1);
    start_batch(4);
    k = 0;
    while (!(pulses == 2 && bus.dut_is_running) && k < 2000) begin tick(); k++; end
    chk("t5_reached_run2", bus.dut_is_running, 1);
    repeat (20) tick();
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("t5_do_run_low", bus.dut_do_run, 0);
    chk("t5_done", bus.done, 1);
    chk("t5_aborted_lit", bus.aborted, 1);
    chk("t5_pass_lit", bus.pass_count, 1);
    tick();
    chk("t5_busy_low", bus.busy, 0);
    wait_model_idle();

    // Zero-run batch clears statistics and the sticky abort flag
    clear_runs();
    model_expect(0, 0);
    start_batch(0);
    chk("t5z_done", bus.done, 1);
    chk("t5z_aborted_cleared", bus.aborted, 0);
    tick();
    chk("t5z_busy_low", bus.busy, 0);

    // Asynchronous reset during run 2
    clear_runs();
    for (int i = 0; i < 3; i++) set_run(i, 2, 100, 1'b1);
    start_batch(3);
    k = 0;
    while (!(pulses == 2 && bus.dut_is_running) && k < 2000) begin tick(); k++; end
    repeat (10) tick();
    chk("t6_pass_before_rst", bus.pass_count, 1);
    done_seen = 0;
    #2 reset = 1'b1;
    #1;
    chk("t6_async_do_run", bus.dut_do_run, 0);
    chk("t6_async_busy", bus.busy, 0);
    chk("t6_async_pass", bus.pass_count, 0);
    chk("t6_async_last", bus.last_cycles, 0);
    chk("t6_async_max", bus.max_cycles, 0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
    batch_three_pass();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
